// File: rtl/lt24_qsys_irq_pkg.sv
// Shared constants for the lt24_qsys interrupt controller: register map
// addresses, source limits and the ACTIVE register layout.
package lt24_qsys_irq_pkg;

  localparam logic [2:0] ADDR_PENDING    = 3'd0;
  localparam logic [2:0] ADDR_ENABLE     = 3'd1;
  localparam logic [2:0] ADDR_EDGE_MODE  = 3'd2;
  localparam logic [2:0] ADDR_ACTIVE     = 3'd3;
  localparam logic [2:0] ADDR_OVERRUN    = 3'd4;
  localparam logic [2:0] ADDR_MISS_COUNT = 3'd5;
  localparam logic [2:0] ADDR_SW_TRIG    = 3'd6;

  localparam int MAX_SRC          = 16;
  localparam int ACTIVE_VALID_BIT = 15;

  localparam logic [15:0] MISS_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/lt24_qsys_irq_prio_enc.sv
// Lowest-index-wins priority encoder; index reads 0 when nothing is requesting.
module lt24_qsys_irq_prio_enc
  import lt24_qsys_irq_pkg::*;
#(
  parameter int N_SRC = 8
) (
  input  logic [N_SRC-1:0] req,
  output logic             valid,
  output logic [3:0]       index
);

  // Scan high to low so the lowest set bit is the last (winning) assignment.
  always_comb begin
    index = 4'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) index = 4'(i);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/lt24_qsys_irq_ctrl.sv
// Interrupt aggregator: per-source pending/enable/edge-mode registers, overrun
// tracking, priority report and a single registered irq, on a 16-bit Avalon-MM slave.
module lt24_qsys_irq_ctrl
  import lt24_qsys_irq_pkg::*;
#(
  parameter int          N_SRC         = 8,
  parameter logic [15:0] RST_EDGE_MODE = 16'hFFFF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [15:0]      writedata,
  output logic [15:0]      readdata,
  input  logic [N_SRC-1:0] irq_in,
  output logic             irq
);

  logic [N_SRC-1:0] pending_reg, pending_next;
  logic [N_SRC-1:0] enable_reg;
  logic [N_SRC-1:0] edge_mode_reg;
  logic [N_SRC-1:0] overrun_reg, overrun_next;
  logic [N_SRC-1:0] irq_in_d_reg;
  logic [15:0]      miss_count_reg, miss_count_next;

  logic [N_SRC-1:0] edge_vec, overrun_event;
  logic [N_SRC-1:0] w1c_pending, w1c_overrun, sw_trig;
  logic [N_SRC-1:0] wdata_src;
  logic             write_en;
  logic             wr_pending, wr_enable, wr_edge_mode, wr_overrun, wr_miss, wr_sw_trig;
  logic             act_valid;
  logic [3:0]       act_index;
  logic [15:0]      active_word, read_mux;

  assign write_en     = chipselect & ~write_n;
  assign wr_pending   = write_en && (address == ADDR_PENDING);
  assign wr_enable    = write_en && (address == ADDR_ENABLE);
  assign wr_edge_mode = write_en && (address == ADDR_EDGE_MODE);
  assign wr_overrun   = write_en && (address == ADDR_OVERRUN);
  assign wr_miss      = write_en && (address == ADDR_MISS_COUNT);
  assign wr_sw_trig   = write_en && (address == ADDR_SW_TRIG);

  assign wdata_src   = writedata[N_SRC-1:0];
  assign w1c_pending = {N_SRC{wr_pending}} & wdata_src;
  assign w1c_overrun = {N_SRC{wr_overrun}} & wdata_src;
  assign sw_trig     = {N_SRC{wr_sw_trig}} & wdata_src;

  generate
    if (N_SRC < MAX_SRC) begin : g_wdata_hi
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^writedata[15:N_SRC];
    end
  endgenerate

  assign edge_vec = irq_in & ~irq_in_d_reg;

  // A W1C landing with the edge means software is servicing it, so no loss is recorded.
  assign overrun_event = edge_mode_reg & edge_vec & pending_reg & ~w1c_pending;
  assign overrun_next  = overrun_event | (overrun_reg & ~w1c_overrun);

  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
      assign pending_next[gi] = edge_mode_reg[gi]
          ? ((edge_vec[gi] | sw_trig[gi]) ? 1'b1
                                          : (w1c_pending[gi] ? 1'b0 : pending_reg[gi]))
          : (irq_in[gi] | sw_trig[gi]);
    end
  endgenerate

  always_comb begin
    miss_count_next = miss_count_reg;
    if (wr_miss)
      miss_count_next = 16'd0;
    else if ((|overrun_event) && (miss_count_reg != MISS_COUNT_MAX))
      miss_count_next = miss_count_reg + 16'd1;
  end

  lt24_qsys_irq_prio_enc #(
    .N_SRC (N_SRC)
  ) u_prio_enc (
    .req   (pending_reg & enable_reg),
    .valid (act_valid),
    .index (act_index)
  );

  always_comb begin
    active_word                   = 16'd0;
    active_word[ACTIVE_VALID_BIT] = act_valid;
    active_word[3:0]              = act_index;
  end

  always_comb begin
    read_mux = 16'd0;
    case (address)
      ADDR_PENDING:    read_mux = 16'(pending_reg);
      ADDR_ENABLE:     read_mux = 16'(enable_reg);
      ADDR_EDGE_MODE:  read_mux = 16'(edge_mode_reg);
      ADDR_ACTIVE:     read_mux = active_word;
      ADDR_OVERRUN:    read_mux = 16'(overrun_reg);
      ADDR_MISS_COUNT: read_mux = miss_count_reg;
      default:         read_mux = 16'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_reg    <= '0;
      enable_reg     <= '0;
      edge_mode_reg  <= RST_EDGE_MODE[N_SRC-1:0];
      overrun_reg    <= '0;
      miss_count_reg <= 16'd0;
      irq_in_d_reg   <= '0;
      readdata       <= 16'd0;
      irq            <= 1'b0;
    end else begin
      pending_reg    <= pending_next;
      overrun_reg    <= overrun_next;
      miss_count_reg <= miss_count_next;
      irq_in_d_reg   <= irq_in;
      if (wr_enable)    enable_reg    <= wdata_src;
      if (wr_edge_mode) edge_mode_reg <= wdata_src;
      readdata       <= read_mux;
      irq            <= |(pending_reg & enable_reg);
    end
  end

endmodule

// File: tb/tb_lt24_qsys_irq_ctrl.sv
// Scoreboarded bench for lt24_qsys_irq_ctrl: register reads queue their expected
// value at issue and are compared when the registered readdata appears.
module tb_lt24_qsys_irq_ctrl;
  import lt24_qsys_irq_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [2:0]   address;
  logic         chipselect;
  logic         write_n;
  logic [15:0]  writedata;
  logic [15:0]  readdata;
  logic [N-1:0] irq_in;
  logic         irq;

  int checks_total  = 0;
  int checks_passed = 0;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];

  lt24_qsys_irq_ctrl #(
    .N_SRC         (N),
    .RST_EDGE_MODE (16'hFFFF)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks_total++;
    if (obs === exp) begin
      checks_passed++;
      $display("check %-16s got 0x%04h exp 0x%04h ok", tag, obs, exp);
    end else begin
      $display("FAIL %-16s got 0x%04h exp 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [15:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic reg_rd(input logic [2:0] a, input string tag, input logic [15:0] exp);
    sb_item_t item;
    item.tag = tag;
    item.exp = exp;
    sb_q.push_back(item);
    address = a;
    tick();
    if (sb_q.size() == 0) begin
      check("sb_underflow", 16'd1, 16'd0);
    end else begin
      item = sb_q.pop_front();
      check(item.tag, readdata, item.exp);
    end
  endtask

  task automatic pulse(input logic [N-1:0] v);
    irq_in = v;
    tick();
    irq_in = '0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 16'd0;
    irq_in     = '0;
    tick();
    tick();
    check("rst_irq", 16'(irq), 16'h0000);
    check("rst_readdata", readdata, 16'h0000);
    reset_n = 1'b1;
    tick();
    reg_rd(ADDR_PENDING,    "rst_pending",  16'h0000);
    reg_rd(ADDR_ENABLE,     "rst_enable",   16'h0000);
    reg_rd(ADDR_EDGE_MODE,  "rst_edge_mode", 16'h00FF);
    reg_rd(ADDR_OVERRUN,    "rst_overrun",  16'h0000);
    reg_rd(ADDR_MISS_COUNT, "rst_miss",     16'h0000);

    // Single edge on source 0, then service it.
    reg_wr(ADDR_ENABLE, 16'h0001);
    irq_in = 8'h01;
    tick();
    check("t1_irq_at_T", 16'(irq), 16'h0000);
    irq_in = '0;
    reg_rd(ADDR_PENDING, "t1_pending", 16'h0001);
    check("t1_irq_T1", 16'(irq), 16'h0001);
    reg_rd(ADDR_ACTIVE, "t1_active", 16'h8000);
    reg_wr(ADDR_PENDING, 16'h0001);
    reg_rd(ADDR_ACTIVE, "t1_active_clr", 16'h0000);
    check("t1_irq_clr", 16'(irq), 16'h0000);

    // Priority between sources 5 and 3.
    reg_wr(ADDR_ENABLE, 16'h00FF);
    pulse(8'h28);
    reg_rd(ADDR_ACTIVE, "t2_active_3", 16'h8003);
    reg_wr(ADDR_PENDING, 16'h0008);
    reg_rd(ADDR_ACTIVE, "t2_active_5", 16'h8005);
    reg_wr(ADDR_ENABLE, 16'h0000);
    reg_rd(ADDR_PENDING, "t2_pending", 16'h0020);
    check("t2_irq_dis", 16'(irq), 16'h0000);
    reg_wr(ADDR_PENDING, 16'h0020);

    // Overruns and miss counting.
    pulse(8'h01);
    pulse(8'h01);
    pulse(8'h01);
    reg_rd(ADDR_OVERRUN,    "t3_overrun_1", 16'h0001);
    reg_rd(ADDR_MISS_COUNT, "t3_miss_2",    16'h0002);
    pulse(8'h06);
    pulse(8'h06);
    reg_rd(ADDR_MISS_COUNT, "t3_miss_3",    16'h0003);
    reg_rd(ADDR_OVERRUN,    "t3_overrun_7", 16'h0007);
    reg_wr(ADDR_MISS_COUNT, 16'h1234);
    reg_rd(ADDR_MISS_COUNT, "t3_miss_clr",  16'h0000);
    reg_wr(ADDR_OVERRUN, 16'h00FF);
    reg_wr(ADDR_PENDING, 16'h00FF);
    reg_rd(ADDR_OVERRUN, "t3_overrun_clr", 16'h0000);
    reg_rd(ADDR_PENDING, "t3_pending_clr", 16'h0000);

    // Level mode: W1C cannot clear while the input is high.
    reg_wr(ADDR_EDGE_MODE, 16'h0000);
    irq_in = 8'h04;
    tick();
    reg_wr(ADDR_PENDING, 16'h0004);
    reg_rd(ADDR_PENDING, "t4_level_hold", 16'h0004);
    irq_in = '0;
    tick();
    reg_rd(ADDR_PENDING, "t4_level_drop", 16'h0000);
    reg_wr(ADDR_EDGE_MODE, 16'h00FF);

    // Edge coincident with W1C: set wins, no overrun.
    pulse(8'h01);
    irq_in = 8'h01;
    reg_wr(ADDR_PENDING, 16'h0001);
    irq_in = '0;
    tick();
    reg_rd(ADDR_PENDING,    "t5_set_wins",  16'h0001);
    reg_rd(ADDR_OVERRUN,    "t5_no_ovr",    16'h0000);
    reg_rd(ADDR_MISS_COUNT, "t5_no_miss",   16'h0000);
    // New overrun racing an OVERRUN W1C.
    irq_in = 8'h01;
    reg_wr(ADDR_OVERRUN, 16'h0001);
    irq_in = '0;
    tick();
    reg_rd(ADDR_OVERRUN,    "t5_ovr_set_wins", 16'h0001);
    reg_rd(ADDR_MISS_COUNT, "t5_miss_1",       16'h0001);
    // Miss clear racing an increment.
    irq_in = 8'h01;
    reg_wr(ADDR_MISS_COUNT, 16'h0000);
    irq_in = '0;
    tick();
    reg_rd(ADDR_MISS_COUNT, "t5_miss_clr_wins", 16'h0000);
    reg_wr(ADDR_SW_TRIG, 16'h0010);
    reg_rd(ADDR_PENDING, "t5_sw_trig",    16'h0011);
    reg_rd(ADDR_SW_TRIG, "t5_sw_trig_rd", 16'h0000);
    reg_rd(3'd7,         "t5_addr7_rd",   16'h0000);

    // Asynchronous reset while irq is high.
    reg_wr(ADDR_ENABLE, 16'h00FF);
    tick();
    check("t6_irq_pre", 16'(irq), 16'h0001);
    reg_rd(ADDR_PENDING, "t6_pending_pre", 16'h0011);
    reset_n = 1'b0;
    #1;
    check("t6_irq_rst", 16'(irq), 16'h0000);
    check("t6_rd_rst", readdata, 16'h0000);
    irq_in = 8'h01;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    reg_rd(ADDR_PENDING,    "t6_pending_edge", 16'h0001);
    reg_rd(ADDR_ENABLE,     "t6_enable",       16'h0000);
    reg_rd(ADDR_OVERRUN,    "t6_overrun",      16'h0000);
    reg_rd(ADDR_MISS_COUNT, "t6_miss",         16'h0000);
    reg_rd(ADDR_EDGE_MODE,  "t6_edge_mode",    16'h00FF);
    check("t6_irq_post", 16'(irq), 16'h0000);
    irq_in = '0;
    tick();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
